store_unit: RTL

Data-side store path of the CPU core: the write-direction counterpart of the load/immediate extension logic. It takes SB/SH/SW requests from the MEM stage and narrows the 32-bit store operand onto the correct little-endian byte lanes. It drives the data-memory request/acknowledge interface, either with byte strobes or with an internal read-modify-write sequence. Misaligned stores are detected and reported without touching memory.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/store_unit_if.sv | 31 +++
 rtl/store_lane_align.sv | 33 +++
 rtl/store_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory path: access sizes, store-unit
// FSM states and byte-lane geometry.
package mem_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } su_state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// Store request/response and data-memory bus seen by the store unit.
// Handshakes: a request is taken on a clock edge where req_valid && req_ready;
// a memory request (mem_req) holds its payload until the edge where mem_ack is 1.
interface store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        resp_done;
  logic        resp_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ack, mem_rdata,
    output req_ready, resp_done, resp_misalign,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ack, mem_rdata,
    input  req_ready, resp_done, resp_misalign,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_lane_align.sv
// Combinational little-endian lane placement and alignment check for a
// byte/half/word access; shared with the load side for lane selection.
module store_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]           size_i,
  input  logic [1:0]           addr_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          wdata_o,
  output logic [NUM_LANES-1:0] be_o,
  output logic                 misalign_o
);

  always_comb begin
    wdata_o    = data_i;
    be_o       = 4'hF;
    misalign_o = 1'b0;
    case (size_i)
      SIZE_B: begin
        wdata_o = {4{data_i[7:0]}};
        be_o    = 4'b0001 << addr_i;
      end
      SIZE_H: begin
        wdata_o    = {2{data_i[15:0]}};
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_i[0];
      end
      // Word and the reserved encoding both behave as a full-word store.
      default: misalign_o = |addr_i;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store path: places the operand on its byte lanes and writes it
// either with byte strobes or via a read-merge-write sequence (RMW=1).
module store_unit
  import mem_pkg::*;
#(
  parameter bit RMW = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  store_unit_if.slave  bus,
  output su_state_e    state_o
);

  su_state_e            state_q;
  logic                 resp_done_q;
  logic                 resp_misalign_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [31:0]          mem_addr_q;
  logic [31:0]          mem_wdata_q;
  logic [NUM_LANES-1:0] mem_be_q;
  logic [NUM_LANES-1:0] lane_be_q;

  logic [31:0]          al_wdata;
  logic [NUM_LANES-1:0] al_be;
  logic                 al_misalign;
  logic [31:0]          merged_d;

  store_lane_align u_align (
    .size_i     (bus.req_size),
    .addr_i     (bus.req_addr[1:0]),
    .data_i     (bus.req_data),
    .wdata_o    (al_wdata),
    .be_o       (al_be),
    .misalign_o (al_misalign)
  );

  // During the RMW read phase mem_wdata_q still holds the lane-placed operand.
  always_comb begin
    merged_d = bus.mem_rdata;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_be_q[i]) merged_d[8*i +: 8] = mem_wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      resp_done_q     <= 1'b0;
      resp_misalign_q <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
      lane_be_q       <= '0;
    end else begin
      resp_done_q     <= 1'b0;
      resp_misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (al_misalign) begin
              resp_done_q     <= 1'b1;
              resp_misalign_q <= 1'b1;
            end else begin
              mem_req_q   <= 1'b1;
              mem_addr_q  <= word_addr(bus.req_addr);
              mem_wdata_q <= al_wdata;
              lane_be_q   <= al_be;
              // A full-word store needs no merge, so it goes straight to WRITE.
              if (RMW && (al_be != 4'hF)) begin
                state_q  <= ST_READ;
                mem_we_q <= 1'b0;
                mem_be_q <= 4'hF;
              end else begin
                state_q  <= ST_WRITE;
                mem_we_q <= 1'b1;
                mem_be_q <= RMW ? 4'hF : al_be;
              end
            end
          end
        end
        ST_READ: begin
          if (bus.mem_ack) begin
            state_q     <= ST_WRITE;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merged_d;
          end
        end
        ST_WRITE: begin
          if (bus.mem_ack) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            resp_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.resp_done     = resp_done_q;
  assign bus.resp_misalign = resp_misalign_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_be        = mem_be_q;
  assign state_o           = state_q;

endmodule
